// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative radix-2 multiply/divide unit with valid/ready on both
// sides. Operands are reduced to magnitudes on accept, an unsigned core runs
// one step per cycle, and the sign is restored when the result is registered.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nx;

  logic [1:0]       op_r;
  logic             neg_r;   // negate the final result
  logic             skip_r;  // special case: result already in y
  logic [WIDTH-1:0] mb;      // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0] hi;      // product high half / partial remainder
  logic [WIDTH-1:0] lo;      // multiplier shifting out / quotient shifting in
  logic [CW-1:0]    cnt;

  logic             accept, last;
  logic             a_neg, b_neg, dz, ovf, special, neg_in;
  logic [WIDTH-1:0] a_mag, b_mag, spec_y;

  logic [WIDTH:0]   mul_sum, div_sh;
  logic             ge;
  logic [WIDTH-1:0] hi_nx, lo_nx;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] quo_s, rem_s, res;

  assign accept = in_valid && in_ready;
  assign last   = skip_r || (cnt == CW'(WIDTH-1));
  assign zero   = (y == '0);

  // Operand decode at accept: magnitudes, result sign and the two cases that
  // bypass the iterative core.
  always_comb begin
    a_neg   = sgn & a[WIDTH-1];
    b_neg   = sgn & b[WIDTH-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    dz      = op[1] && (b == '0);
    ovf     = op[1] && sgn && (a == MINV) && (b == ONES);
    special = dz | ovf;
    // Remainder follows the dividend; product and quotient follow a^b.
    neg_in  = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
    if (dz) spec_y = op[0] ? a : ONES;
    else    spec_y = op[0] ? '0 : a;
  end

  // One radix-2 step of either the shift-add multiplier or the restoring divider.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mb} : '0);
    div_sh  = {hi, lo[WIDTH-1]};
    ge      = (div_sh >= {1'b0, mb});
    if (op_r[1]) begin
      // When ge, the true difference is below mb, so the low WIDTH bits suffice.
      hi_nx = ge ? (div_sh[WIDTH-1:0] - mb) : div_sh[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], ge};
    end else begin
      hi_nx = mul_sum[WIDTH:1];
      lo_nx = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  // Final result selection with sign restoration, valid on the last step.
  always_comb begin
    prod   = {hi_nx, lo_nx};
    prod_s = neg_r ? -prod : prod;
    quo_s  = neg_r ? -lo_nx : lo_nx;
    rem_s  = neg_r ? -hi_nx : hi_nx;
    unique case (op_r)
      OP_MUL:  res = prod_s[WIDTH-1:0];
      OP_MULH: res = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV:  res = quo_s;
      OP_REM:  res = rem_s;
      default: res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic. Special cases spend one CALC cycle with the step
  // suppressed, which gives them their single-cycle latency.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)    state_nx = CALC;
      CALC:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is held low while reset is asserted.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // Datapath: latch operands on accept, iterate in CALC, register the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r        <= '0;
      neg_r       <= 1'b0;
      skip_r      <= 1'b0;
      mb          <= '0;
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
      y           <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      op_r        <= op;
      neg_r       <= neg_in;
      skip_r      <= special;
      mb          <= op[1] ? b_mag : a_mag;
      hi          <= '0;
      lo          <= op[1] ? a_mag : b_mag;
      cnt         <= '0;
      div_by_zero <= dz;
      if (special) y <= spec_y;
    end else if (state == CALC) begin
      hi  <= hi_nx;
      lo  <= lo_nx;
      cnt <= cnt + CW'(1);
      if (last && !skip_r) y <= res;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: drives a WIDTH=32 and a WIDTH=8 instance; a scoreboard queue
// per instance holds expected results, a monitor pops them on each handshake.
module tb_alu_muldiv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       in_valid, in_ready, out_valid, out_ready, zero, dbz, sgn;
  logic [1:0][1:0]  op;
  logic [1:0][31:0] a, b;
  logic [31:0]      y32;
  logic [7:0]       y8;

  alu_muldiv #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .op(op[0]), .sgn(sgn[0]), .a(a[0]), .b(b[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .y(y32), .zero(zero[0]), .div_by_zero(dbz[0]));

  alu_muldiv #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .op(op[1]), .sgn(sgn[1]), .a(a[1][7:0]), .b(b[1][7:0]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .y(y8), .zero(zero[1]), .div_by_zero(dbz[1]));

  typedef struct {
    logic [31:0] y;
    logic        dbz;
    int          lat;
    longint      e;
  } exp_t;

  exp_t   q0[$], q1[$];
  longint cyc = 0;
  int     n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int d, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, d, act, exp, cyc);
    end
  endfunction

  // Reference: plain arithmetic on sign-extended 64-bit values plus the
  // divide-by-zero / overflow rules.
  function automatic logic [31:0] model(int w, logic [1:0] o, logic s, logic [31:0] x,
                                        logic [31:0] z, output logic dz, output int lat);
    logic [63:0] mask, ux, uz, r, p;
    longint      sx, sz, t;
    mask = (64'd1 << w) - 64'd1;
    ux   = {32'b0, x} & mask;
    uz   = {32'b0, z} & mask;
    sx   = (s && ux[w-1]) ? longint'(ux | ~mask) : longint'(ux);
    sz   = (s && uz[w-1]) ? longint'(uz | ~mask) : longint'(uz);
    dz   = 1'b0;
    lat  = w;
    if (o[1] && uz == 0) begin
      dz = 1'b1; lat = 1;
      r  = o[0] ? ux : mask;
    end else if (o[1] && s && ux == (64'd1 << (w-1)) && uz == mask) begin
      lat = 1;
      r   = o[0] ? 64'd0 : ux;
    end else if (!o[1]) begin
      if (s) begin t = sx * sz; p = t; end
      else   p = ux * uz;
      r = o[0] ? (p >> w) : p;
    end else begin
      if (s) begin t = o[0] ? (sx % sz) : (sx / sz); r = t; end
      else   r = o[0] ? (ux % uz) : (ux / uz);
    end
    return 32'(r & mask);
  endfunction

  task automatic issue(int d, logic [1:0] o, logic s, logic [31:0] x, logic [31:0] z,
                       logic [31:0] ey, logic edz, int lat);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    in_valid[d] = 1'b1; op[d] = o; sgn[d] = s; a[d] = x; b[d] = z;
    while (!in_ready[d] && n < 500) begin @(negedge clk); n++; end
    if (!in_ready[d]) begin
      chk("accept_timeout", d, 0, 1);
      in_valid[d] = 1'b0;
      return;
    end
    e.y = ey; e.dbz = edz; e.lat = lat; e.e = cyc;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk); #1;
    // Operands only need to be stable in the accepting cycle.
    in_valid[d] = 1'b0; op[d] = 2'($urandom); a[d] = $urandom; b[d] = $urandom;
  endtask

  task automatic issue_m(int d, logic [1:0] o, logic s, logic [31:0] x, logic [31:0] z);
    logic        edz;
    int          lat;
    logic [31:0] ey;
    ey = model(d ? 8 : 32, o, s, x, z, edz, lat);
    issue(d, o, s, x, z, ey, edz, lat);
  endtask

  task automatic drain(int d);
    int n = 0;
    while ((d == 0 ? q0.size() : q1.size()) > 0 && n < 2000) begin @(negedge clk); n++; end
    chk("drain_timeout", d, d == 0 ? q0.size() : q1.size(), 0);
  endtask

  // Monitor: latency, stability while presented, and value on each handshake.
  logic [1:0]  prev_ov = '0;
  longint      rise [2];
  logic [32:0] held [2];
  logic        stab [2];
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic [32:0] cur;
      exp_t        e;
      logic        got;
      cur = {dbz[d], (d == 1) ? {24'b0, y8} : y32};
      if (out_valid[d]) begin
        if (!prev_ov[d]) begin rise[d] = cyc; held[d] = cur; stab[d] = 1'b1; end
        else if (cur != held[d]) stab[d] = 1'b0;
        if (in_ready[d]) stab[d] = 1'b0;
        if (out_ready[d]) begin
          got = 1'b0;
          if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
          if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
          if (!got) chk("unexpected_result", d, 1, 0);
          else begin
            chk("y", d, cur[31:0], e.y);
            chk("zero", d, zero[d], e.y == 0);
            chk("div_by_zero", d, cur[32], e.dbz);
            chk("latency", d, rise[d] - e.e - 1, e.lat);
            chk("stable_excl", d, stab[d], 1);
          end
        end
      end
      prev_ov[d] = out_valid[d];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int alist [16] = '{0, 1, 2, 3, 7, 'h10, 'h40, 'h55, 'h7F, 'h80, 'h81, 'hAA, 'hC0, 'hF0, 'hFE, 'hFF};

  initial begin
    rst = 1'b1; in_valid = '0; out_ready = 2'b11; op = '0; sgn = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 0, out_valid[0], 0);
    chk("rst_out_valid", 1, out_valid[1], 0);
    chk("rst_y", 0, y32, 0);
    chk("rst_y", 1, y8, 0);
    chk("rst_zero", 0, zero[0], 1);
    chk("rst_dbz", 0, dbz[0], 0);
    chk("rst_in_ready", 0, in_ready[0], 0);
    chk("rst_in_ready", 1, in_ready[1], 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 0, in_ready[0], 1);
    chk("in_ready_after_rst", 1, in_ready[1], 1);

    // Directed vectors with hand-derived results.
    issue(0, 2'b00, 0, 32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 0, 32);
    issue(0, 2'b01, 0, 32'h0000_1234, 32'h0000_5678, 32'h0,         0, 32);
    issue(0, 2'b00, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         0, 32);
    issue(0, 2'b01, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         0, 32);
    issue(0, 2'b01, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 32);
    issue(0, 2'b10, 1, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 0, 32);
    issue(0, 2'b11, 1, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 0, 32);
    issue(0, 2'b10, 0, 32'h7,         32'hFFFF_FFFE, 32'h0,         0, 32);
    issue(0, 2'b11, 0, 32'h7,         32'hFFFF_FFFE, 32'h7,         0, 32);
    for (int s = 0; s < 2; s++) begin
      issue(0, 2'b10, 1'(s), 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1, 1);
      issue(0, 2'b11, 1'(s), 32'h1234_5678, 32'h0, 32'h1234_5678, 1, 1);
    end
    issue(0, 2'b10, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1);
    issue(0, 2'b11, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0, 1);
    issue(0, 2'b00, 0, 32'h1234_5678, 32'h0,         32'h0,         0, 32);
    issue(1, 2'b10, 1, 32'h80, 32'hFF, 32'h80, 0, 1);
    issue(1, 2'b11, 1, 32'hF9, 32'h02, 32'hFF, 0, 8);
    issue(1, 2'b01, 0, 32'hFF, 32'hFF, 32'hFE, 0, 8);
    issue(1, 2'b00, 1, 32'hFD, 32'h05, 32'hF1, 0, 8);
    drain(0);
    drain(1);

    // Backpressure: result held for 10 cycles while a new request is offered.
    @(posedge clk); #1 out_ready[0] = 1'b0;
    issue(0, 2'b00, 1, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFF1, 0, 32);
    for (int n = 0; n < 100 && !out_valid[0]; n++) @(negedge clk);
    chk("bp_out_valid", 0, out_valid[0], 1);
    @(negedge clk);
    in_valid[0] = 1'b1; op[0] = 2'b10; sgn[0] = 1'b0; a[0] = 32'h99; b[0] = 32'h3;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_in_ready", 0, in_ready[0], 0);
    end
    in_valid[0] = 1'b0;
    @(posedge clk); #1 out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_consume", 0, in_ready[0], 1);
    chk("out_valid_after_consume", 0, out_valid[0], 0);

    // Reset after CALC step 10 discards the in-flight result.
    issue(0, 2'b00, 0, 32'h0001_0001, 32'h0000_FFFF, 32'h0, 0, 32);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 0, out_valid[0], 0);
    chk("midrst_y", 0, y32, 0);
    chk("midrst_zero", 0, zero[0], 1);
    q0.delete();
    @(posedge clk); #1 rst = 1'b0;
    issue_m(0, 2'b10, 1, 32'hFFFF_8000, 32'h0000_0077);
    drain(0);

    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          logic [31:0] x, z;
          x = $urandom; z = $urandom;
          if (i % 16 == 0) z = 32'h0;
          if (i % 16 == 1) begin x = 32'h8000_0000; z = 32'hFFFF_FFFF; end
          if (i % 8 == 2) begin x = x >> $urandom_range(0, 31); z = z >> $urandom_range(0, 31); end
          issue_m(0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), x, z);
        end
      end
      begin
        for (int ai = 0; ai < 16; ai++)
          for (int bi = 0; bi < 256; bi++) begin
            int combo;
            combo = (bi + ai) % 4;
            issue_m(1, {1'b1, 1'(combo & 1)}, 1'(combo >> 1), 32'(alist[ai]), 32'(bi));
          end
        for (int i = 0; i < 200; i++)
          issue_m(1, {1'b0, 1'($urandom_range(0, 1))}, 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)));
      end
    join
    drain(0);
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
